// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the 5-stage MIPS pipeline: per-register
// countdowns, RAW stalls, redirect squash with scoreboard rollback.
module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int REGW     = 5,
  parameter int FWD_EN   = 1,
  parameter int LAT_ALU  = 1,
  parameter int LAT_LOAD = 2,
  parameter int LAT_WB   = 3,
  parameter int CNTW     = 3,
  parameter int STATW    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             issue_valid,
  input  logic [REGW-1:0]  issue_rs,
  input  logic [REGW-1:0]  issue_rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             issue_wr,
  input  logic [REGW-1:0]  issue_wsel,
  input  logic             issue_load,
  input  logic             redirect,
  input  logic             halt,
  output logic             pc_hold,
  output logic             enable_ID,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             flush_MEM,
  output logic [NREGS-1:0] busy_mask,
  output logic [STATW-1:0] stall_cnt,
  output logic [STATW-1:0] flush_cnt
);

  localparam logic [CNTW-1:0] L_ALU =
    CNTW'(FWD_EN != 0 ? LAT_ALU : LAT_WB);
  localparam logic [CNTW-1:0] L_LD =
    CNTW'(FWD_EN != 0 ? LAT_LOAD : LAT_WB);
  localparam logic [CNTW-1:0] ONE = CNTW'(1);
  localparam logic [CNTW-1:0] TWO = CNTW'(2);

  logic [CNTW-1:0]  cnt_q [NREGS];
  logic [CNTW-1:0]  cnt_d [NREGS];
  logic             last_v_q;
  logic [REGW-1:0]  last_w_q;
  logic [CNTW-1:0]  last_prev_q, last_prev_d;
  logic [STATW-1:0] stall_q, flush_q;

  logic            raw, issue, do_redir, do_stall;
  logic [CNTW-1:0] lat, rb;

  // A count of 1 means the producer is one stage ahead and is bypassed.
  assign raw = issue_valid &
    ((uses_rs & (cnt_q[issue_rs] > ONE)) |
     (uses_rt & (cnt_q[issue_rt] > ONE)));

  assign do_redir = ~halt & redirect;
  assign do_stall = ~halt & ~redirect & raw;
  assign issue    = ~halt & issue_valid & issue_wr &
                    (issue_wsel != '0) & ~raw & ~redirect;
  assign lat      = issue_load ? L_LD : L_ALU;
  assign rb       = (last_prev_q > TWO) ? last_prev_q - TWO : '0;
  assign last_prev_d = issue ? cnt_q[issue_wsel] : last_prev_q;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - ONE : '0;
      if (issue && REGW'(r) == issue_wsel && cnt_d[r] < lat)
        cnt_d[r] = lat;
      if (do_redir && last_v_q && REGW'(r) == last_w_q)
        cnt_d[r] = rb;
      if (halt)
        cnt_d[r] = cnt_q[r];
      if (r == 0)
        cnt_d[r] = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      last_v_q    <= 1'b0;
      last_w_q    <= '0;
      last_prev_q <= '0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else if (!halt) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      last_v_q    <= issue;
      last_w_q    <= issue_wsel;
      last_prev_q <= last_prev_d;
      if (do_stall && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (do_redir && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  always_comb begin
    pc_hold   = 1'b0;
    enable_ID = 1'b1;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_MEM = 1'b0;
    unique case (1'b1)
      halt: begin
        pc_hold   = 1'b1;
        enable_ID = 1'b0;
      end
      do_redir: begin
        flush_ID  = 1'b1;
        flush_EX  = 1'b1;
        flush_MEM = 1'b1;
      end
      do_stall: begin
        pc_hold   = 1'b1;
        enable_ID = 1'b0;
        flush_EX  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
